// File: rtl/riscv_mmio_uart_tx.sv
// riscv_mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports:
//   i_clk, i_rst (async, active-low)   clock and reset
//   i_sel, i_addr, i_we, i_wdata       single-cycle data bus slave (word offsets 0..3)
//   o_rdata                            combinational read data, 0 when not selected
//   o_tx                               serial line, idles high, LSB first
//   o_busy                             FIFO non-empty or frame in flight (registered)
// Register map: 0 TXDATA, 1 STATUS {ovf, tx_active, empty, full}, 2 DIV, 3 COUNT.
module riscv_mmio_uart_tx #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_sel,
   input  logic [1:0]      i_addr,
   input  logic            i_we,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_tx,
   output logic            o_busy
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = 16;

   localparam logic [1:0] A_TXDATA = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_DIV    = 2'd2;
   localparam logic [1:0] A_COUNT  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   act_div_q, act_div_d;
   logic [DW-1:0]   div_q, div_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            full_c, empty_c, wr_txdata_c, push_c, pop_c;
   logic            unused_wdata_c;

   assign unused_wdata_c = ^i_wdata[XLEN-1:DW];

   assign full_c      = (count_q == CW'(FIFO_DEPTH));
   assign empty_c     = (count_q == '0);
   assign wr_txdata_c = i_sel && i_we && (i_addr == A_TXDATA);
   // Fullness is judged before the edge, so a pop on the same edge does not rescue a push.
   assign push_c      = wr_txdata_c && !full_c;

   // Register writes and FIFO bookkeeping
   always_comb begin
      ovf_d    = ovf_q;
      div_d    = div_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_sel && i_we && (i_addr == A_STATUS) && i_wdata[3]) begin
         ovf_d = 1'b0;
      end
      if (wr_txdata_c && full_c) begin
         ovf_d = 1'b1;
      end
      if (i_sel && i_we && (i_addr == A_DIV)) begin
         div_d = (i_wdata[DW-1:0] < 16'd2) ? 16'd2 : i_wdata[DW-1:0];
      end
      if (push_c) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
   end

   // Transmit FSM next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_div_d = act_div_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      pop_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_c) begin
               pop_c     = 1'b1;
               shift_d   = mem_q[rd_ptr_q];
               act_div_d = div_q;
               cnt_d     = div_q - 16'd1;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               cnt_d   = act_div_q - 16'd1;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = act_div_q - 16'd1;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               // Back-to-back: reload straight into START without passing IDLE.
               if (!empty_c) begin
                  pop_c     = 1'b1;
                  shift_d   = mem_q[rd_ptr_q];
                  act_div_d = div_q;
                  cnt_d     = div_q - 16'd1;
                  state_d   = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered line and busy derived from the next state
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (count_d != '0) || (state_d != S_IDLE);
   end

   // Combinational read mux, no side effects
   always_comb begin
      o_rdata = '0;
      if (i_sel) begin
         case (i_addr)
            A_STATUS: o_rdata = XLEN'({ovf_q, (state_q != S_IDLE), empty_c, full_c});
            A_DIV:    o_rdata = XLEN'(div_q);
            A_COUNT:  o_rdata = XLEN'(count_q);
            default:  o_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         act_div_q <= 16'(CLK_DIV);
         div_q     <= 16'(CLK_DIV);
         idx_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         act_div_q <= act_div_d;
         div_q     <= div_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   // FIFO storage; contents are don't-care until the pointers say otherwise
   always_ff @(posedge i_clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= i_wdata[7:0];
      end
   end

   assign o_tx   = tx_q;
   assign o_busy = busy_q;

endmodule

// File: tb/tb_riscv_mmio_uart_tx.sv
// Self-checking bench for riscv_mmio_uart_tx: a frame-level line model schedules each
// byte's start cycle and divisor; a line monitor decodes o_tx and checks against it.
module tb_riscv_mmio_uart_tx;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned CLK_DIV = 868;
   localparam int unsigned DEPTH   = 4;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic            i_sel = 1'b0;
   logic            i_we  = 1'b0;
   logic [1:0]      i_addr = 2'd0;
   logic [XLEN-1:0] i_wdata = '0;
   logic [XLEN-1:0] o_rdata;
   logic            o_tx;
   logic            o_busy;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   riscv_mmio_uart_tx #(.XLEN(XLEN), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sel  (i_sel),
      .i_addr (i_addr),
      .i_we   (i_we),
      .i_wdata(i_wdata),
      .o_rdata(o_rdata),
      .o_tx   (o_tx),
      .o_busy (o_busy)
   );

   typedef struct {
      logic [7:0] data;
      int         div;
      int         start;
   } frame_t;

   frame_t     sb_q[$];
   logic [7:0] m_fifo[$];
   int         cyc   = 0;
   int         m_div = CLK_DIV;
   int         m_end = 0;
   bit         m_ovf = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a frame occupies the line for 10*div cycles; the next queued
   // byte starts at the edge where the previous frame ends, using DIV as it stood
   // before that edge.
   always @(posedge i_clk) begin
      int     dpre;
      bit     fullpre;
      frame_t f;
      cyc++;
      if (!i_rst) begin
         m_fifo.delete();
         sb_q.delete();
         m_div = CLK_DIV;
         m_end = 0;
         m_ovf = 1'b0;
      end else begin
         dpre    = m_div;
         fullpre = (m_fifo.size() == DEPTH);
         if (m_fifo.size() != 0 && cyc >= m_end) begin
            f.data  = m_fifo.pop_front();
            f.div   = dpre;
            f.start = cyc;
            sb_q.push_back(f);
            m_end = cyc + 10 * dpre;
         end
         if (i_sel && i_we) begin
            case (i_addr)
               2'd0: if (fullpre) m_ovf = 1'b1; else m_fifo.push_back(i_wdata[7:0]);
               2'd1: if (i_wdata[3]) m_ovf = 1'b0;
               2'd2: m_div = (i_wdata[15:0] < 16'd2) ? 2 : int'(i_wdata[15:0]);
               default: ;
            endcase
         end
      end
   end

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd1:    return {28'd0, m_ovf, (cyc < m_end), (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
         2'd2:    return 32'(m_div);
         2'd3:    return 32'(m_fifo.size());
         default: return 32'd0;
      endcase
   endfunction

   // Line monitor: decodes each frame and compares it with the scoreboard head.
   bit     in_frame = 1'b0;
   int     k   = 0;
   int     bad = 0;
   frame_t cur;

   always @(negedge i_clk) begin
      int   b;
      logic e;
      if (!i_rst) begin
         in_frame = 1'b0;
         sb_q.delete();
      end else begin
         check("busy", longint'(o_busy), longint'((m_fifo.size() != 0) || (cyc < m_end)));
         if (!in_frame) begin
            if (o_tx == 1'b0) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_start", 64'd1, 64'd0);
               end else begin
                  cur = sb_q.pop_front();
                  check("start_cycle", longint'(cyc), longint'(cur.start));
                  in_frame = 1'b1;
                  k   = 0;
                  bad = 0;
               end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].start) begin
               cur = sb_q.pop_front();
               check("start_cycle", longint'(cyc), longint'(cur.start));
            end
         end
         if (in_frame) begin
            b = k / cur.div;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur.data[b-1];
            if (o_tx !== e) bad++;
            k++;
            if (k == 10 * cur.div) begin
               check($sformatf("frame_%02h_div%0d", cur.data, cur.div), longint'(bad), 64'd0);
               in_frame = 1'b0;
            end
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge i_clk);
      i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
      @(posedge i_clk);
      #1;
      i_sel = 1'b0; i_we = 1'b0;
   endtask

   task automatic rd_model(input logic [1:0] a, input string name);
      @(negedge i_clk);
      i_sel = 1'b1; i_we = 1'b0; i_addr = a;
      #1;
      check(name, longint'(o_rdata), longint'(m_read(a)));
      i_sel = 1'b0;
   endtask

   task automatic rd_const(input logic [1:0] a, input logic [31:0] exp, input string name);
      @(negedge i_clk);
      i_sel = 1'b1; i_we = 1'b0; i_addr = a;
      #1;
      check(name, longint'(o_rdata), longint'(exp));
      i_sel = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((sb_q.size() != 0 || m_fifo.size() != 0 || cyc < m_end || in_frame) && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check("drain_in_budget", longint'(n < budget), 64'd1);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lows;
      int r;
      // Reset
      #1 i_rst = 1'b0;
      #1;
      check("reset_tx", longint'(o_tx), 64'd1);
      check("reset_busy", longint'(o_busy), 64'd0);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      rd_const(2'd1, 32'h2, "reset_status");
      rd_const(2'd2, 32'd868, "reset_div");
      rd_const(2'd3, 32'd0, "reset_count");
      rd_const(2'd0, 32'd0, "txdata_read");

      // Single 0x55 frame at DIV=4
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h55);
      @(negedge i_clk);
      check("busy_after_write", longint'(o_busy), 64'd1);
      check("tx_before_start", longint'(o_tx), 64'd1);
      @(negedge i_clk);
      check("tx_start_bit", longint'(o_tx), 64'd0);
      wait_idle(200);
      check("busy_after_frame", longint'(o_busy), 64'd0);

      // Burst at DIV=2: fill, overflow, clear
      wr(2'd2, 32'd2);
      for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i));
      rd_const(2'd3, 32'd4, "count_after_five");
      wr(2'd0, 32'hAA);
      rd_const(2'd1, 32'hD, "status_ovf");
      rd_const(2'd3, 32'd4, "count_after_drop");
      wr(2'd1, 32'h8);
      rd_const(2'd1, 32'h5, "status_ovf_cleared");
      wait_idle(400);

      // Divisor clamping and truncation
      wr(2'd2, 32'd0);
      rd_const(2'd2, 32'd2, "div_zero_clamped");
      wr(2'd2, 32'd1);
      rd_const(2'd2, 32'd2, "div_one_clamped");
      wr(2'd2, 32'h12345);
      rd_const(2'd2, 32'h2345, "div_truncated");

      // DIV change mid-frame applies only to the following frames
      wr(2'd2, 32'd4);
      wr(2'd0, 32'hC3);
      wr(2'd0, 32'h3C);
      wr(2'd0, 32'h99);
      repeat (5) @(negedge i_clk);
      wr(2'd2, 32'd8);
      rd_model(2'd1, "status_midframe");
      wait_idle(600);

      // Reset during data bit 3 of 0xF0
      wr(2'd2, 32'd4);
      wr(2'd0, 32'hF0);
      repeat (18) @(negedge i_clk);
      check("tx_data_bit3", longint'(o_tx), 64'd0);
      #2 i_rst = 1'b0;
      #1;
      check("reset_async_tx", longint'(o_tx), 64'd1);
      check("reset_async_busy", longint'(o_busy), 64'd0);
      i_sel = 1'b1; i_addr = 2'd3;
      #1;
      check("reset_async_count", longint'(o_rdata), 64'd0);
      i_sel = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      lows = 0;
      repeat (40) begin
         @(negedge i_clk);
         if (o_tx == 1'b0) lows++;
      end
      check("post_reset_line_idle", longint'(lows), 64'd0);
      rd_const(2'd2, 32'd868, "post_reset_div");

      // Writes with i_sel low are ignored and reads return 0
      for (int a = 0; a < 4; a++) begin
         @(negedge i_clk);
         i_sel = 1'b0; i_we = 1'b1; i_addr = 2'(a); i_wdata = 32'h77;
         #1;
         check($sformatf("unsel_rdata_%0d", a), longint'(o_rdata), 64'd0);
      end
      @(negedge i_clk);
      i_we = 1'b0;
      rd_const(2'd3, 32'd0, "unsel_count");
      rd_const(2'd2, 32'd868, "unsel_div");
      check("unsel_busy", longint'(o_busy), 64'd0);

      // Randomized traffic against the model
      wr(2'd2, 32'd3);
      repeat (150) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3, 4, 5: wr(2'd0, $urandom);
            6:                wr(2'd2, 32'($urandom_range(0, 6)));
            7:                wr(2'd1, $urandom);
            8:                rd_model(2'($urandom_range(0, 3)), "rand_read");
            default:          repeat ($urandom_range(1, 30)) @(negedge i_clk);
         endcase
      end
      wait_idle(5000);
      rd_model(2'd1, "final_status");
      rd_model(2'd3, "final_count");
      check("scoreboard_empty", longint'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_mmio_uart_tx.md
# riscv_mmio_uart_tx

Memory-mapped UART transmitter that answers the core's single-cycle data bus in the I/O region (data address bit XLEN-1 set), alongside the LED/switch port. Software writes bytes into a small TX FIFO and polls a status register. The block serialises each byte as 8N1, LSB first, on a single output line, with a programmable baud divisor.

## Interface
- XLEN, 32, data bus width.
- CLK_DIV, 868, reset value of the baud divisor in clock cycles per bit (100 MHz / 115200).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, 2 to 16.
- i_clk  in  1  system clock; all state on its rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_sel  in  1  block selected; the top asserts it when the data address is in I/O space and decodes to this block.
- i_addr  in  2  word offset, taken from data address bits [3:2].
- i_we  in  1  write strobe; the core's memory-write control.
- i_wdata  in  XLEN  write data.
- o_rdata  out  XLEN  read data; combinational, valid in the same cycle as i_sel/i_addr.
- o_tx  out  1  serial line; idles high.
- o_busy  out  1  high when the FIFO is non-empty or a frame is in flight.

## Operation
- Register map by i_addr, applying only when i_sel=1:
  - 0 TXDATA. A write pushes i_wdata[7:0]. If the FIFO is full, the byte is dropped and the sticky OVF bit is set. Reads return 0.
  - 1 STATUS. Read bits: [0] full, [1] empty, [2] tx_active (FSM not IDLE), [3] OVF; all other bits 0. Writing with i_wdata[3]=1 clears OVF; other write bits are ignored.
  - 2 DIV. Read returns the zero-extended 16-bit divisor. Write loads i_wdata[15:0]; values below 2 are stored as 2.
  - 3 COUNT. Read returns the FIFO occupancy, 0..FIFO_DEPTH. Writes are ignored.
- When i_sel=0, o_rdata is 0 and writes have no effect.
- Full is evaluated before the clock edge. A push while full is dropped even if a pop occurs on the same edge. A push and a pop on the same edge while not full leave COUNT unchanged.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head into the shift register, latch DIV into the active divisor, and go to START.
  - START: o_tx=0 for div cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] for div cycles, shift right, increment the index. After index 7 completes, go to STOP.
  - STOP: o_tx=1 for div cycles. At the end, if the FIFO is non-empty, pop and latch as in IDLE and go directly to START (back-to-back); otherwise go to IDLE.
- A DIV write during a frame affects only the next frame.
- The bit counter is 16 bits and counts down from div-1 to 0. The 3-bit index must not wrap early.
- Reset, including mid-frame: o_tx=1, o_busy=0, FIFO empty, OVF=0, DIV=CLK_DIV, FSM=IDLE. o_tx goes high immediately on reset assertion. No partial frame is resumed.

## Timing
- Reset values: o_tx=1, o_busy=0, o_rdata=0 (when i_sel=0).
- A write accepted at edge k is visible in COUNT/STATUS after edge k.
- From IDLE, the first start-bit cycle begins after edge k+1.
- Frame length is exactly 10·div cycles.
- Back-to-back frames have no idle gap: the next start bit follows the last stop cycle immediately.
- o_busy is registered. It rises after the edge that first makes the FIFO non-empty. It falls after the edge on which STOP completes with the FIFO empty.
- Reads are combinational with no side effects. Reading TXDATA or STATUS does not pop or clear anything.

## Test plan
- Reset, then DIV=4 and write 0x55 → o_tx low for 4 cycles starting one cycle after the write, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles. Total 40 cycles. o_busy spans the frame.
- DIV=2, five TXDATA writes 0x01..0x05 on consecutive cycles with FIFO_DEPTH=4:
  - The first byte pops at once, so four bytes are held and none are dropped (COUNT=4 after the fifth write).
  - A sixth write → OVF=1 and the byte is lost.
  - The line carries 0x01..0x05 back-to-back with no gap. Writing STATUS with bit 3 set clears OVF.
- DIV write of 0 → DIV reads 2. DIV write of 0x12345 → DIV reads 0x2345.
- Change DIV from 4 to 8 mid-frame with two bytes queued → the current frame completes at 4 cycles/bit and the next frame runs at 8 cycles/bit.
- Assert i_rst during data bit 3 → o_tx=1 asynchronously, COUNT=0, o_busy=0. After release with no writes, o_tx stays high.
- i_sel=0 with i_we=1 at offset 0 → no push, and o_rdata=0 for all offsets.
